operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Decode/operand-fetch stage between instruction fetch and execute. Takes fetched
//  instructions, extracts rs1/rs2/rd and drives the register-file read selects.
//  Register-file reads are synchronous (sampled on posedge, written on negedge).
//  Tracks in-flight destination registers in a scoreboard and stalls on RAW hazards.
//  Emits instruction, PC and both operand values to execute over a valid/ready handshake.
// PARAMETERS
//  XLEN      32  data/PC width
//  NREGS     32  architectural registers (index width $clog2(NREGS) = 5)
// PORTS
//  clk            in   1     clock, all state on posedge
//  rst_n          in   1     async active-low reset
//  flush          in   1     sync; discard D and O contents (branch redirect)
//  in_valid       in   1     fetch offers in_instr/in_pc
//  in_ready       out  1     stage accepts this cycle
//  in_instr       in   32    RV32I instruction word
//  in_pc          in   XLEN  its PC
//  rf_read_selA   out  5     to register file port A
//  rf_read_selB   out  5     to register file port B
//  rf_data_outA   in   XLEN  registered read data A (1-cycle latency)
//  rf_data_outB   in   XLEN  registered read data B
//  wb_valid       in   1     writeback retiring a result this cycle
//  wb_rd          in   5     its destination register
//  out_valid      out  1     operands valid to execute
//  out_ready      in   1     execute accepts
//  out_instr      out  32    instruction
//  out_pc         out  XLEN  PC
//  out_rd         out  5     destination (0 if none written)
//  out_rs1_val    out  XLEN  = rf_data_outA passthrough
//  out_rs2_val    out  XLEN  = rf_data_outB passthrough
// BEHAVIOUR
//  - Two slots: D (decode, holds accepted instr) and O (operands, feeds out_*).
//  - Reset: D/O valid=0, scoreboard=0, in_ready=1, out_valid=0, out_instr/pc/rd=0.
//  - in_ready = !D.valid | D->O move this cycle. Accept on in_valid&in_ready.
//  - D->O move when D.valid & !hazard & (!O.valid | out_ready) & !flush.
//  - rf_read_sel* = D.rs1/rs2 when D->O move, else O.rs1/rs2 (holds data while O stalls).
//  - hazard = (uses_rs1 & rs1!=0 & busy(rs1)) | same for rs2; busy(r) = scoreboard[r] &
//    !(wb_valid & wb_rd==r)  |  (O.valid & O.rd==r). Same-cycle WB is not a hazard
//    (negedge write lands before posedge read).
//  - Scoreboard bit set on out_valid&out_ready for out_rd!=0; cleared on wb_valid for wb_rd.
//    Set and clear of same reg in one cycle -> set wins. Bit 0 never set.
//  - Latency: accept -> out_valid min 2 cycles (D, then O after RF read).
//  - out_valid held with stable out_* until out_ready; no combinational in_valid->out path.
//  - flush: D.valid, O.valid <= 0 next edge; accept blocked that cycle; scoreboard kept
//    (only issued instrs set bits, so flushed ones never leak). Flush beats handshake.
//  - uses_rs1/uses_rs2/writes_rd decoded from opcode; unknown opcode: all 0, passed through.
// STRUCTURE
//  - Package core_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR,
//    LUI, AUIPC, SYSTEM), typedef reg_idx_t [4:0], struct dec_fields_t {rs1,rs2,rd,
//    uses_rs1,uses_rs2,writes_rd}, function decode_fields().
//  - Sub-module: scoreboard (set/clear/query, 32 bits, combinational busy per port).
// TESTING
//  - Reset: rst_n low mid-stall -> out_valid=0, in_ready=1, scoreboard 0, async.
//  - addi x5,x0,7 then add x6,x5,x5, no WB -> add stalls in D, in_ready=0; wb x5 -> issues.
//  - WB x5 same cycle add x6,x5,x5 sits in D -> no stall, out_rs1_val=new x5 value.
//  - out_ready=0 for 5 cycles with O holding x1=0xDEAD -> out_rs1_val stays 0xDEAD.
//  - flush with D and O valid -> both dropped, scoreboard unchanged, next instr accepted.
//  - Back-to-back independent instrs, out_ready=1 -> one out_valid per cycle, x0 never stalls.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared RV32I decode definitions for the operand-fetch stage.
//   - opcode localparams for the RV32I major opcodes
//   - reg_idx_t: architectural register index
//   - dec_fields_t / decode_fields(): register fields plus which of them the
//     instruction actually reads or writes
package core_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     uses_rs1;
        logic     uses_rs2;
        logic     writes_rd;
    } dec_fields_t;

    // rd is forced to 0 when the instruction writes nothing, so downstream
    // logic can treat rd==0 as "no destination".
    function automatic dec_fields_t decode_fields(input logic [31:0] instr);
        dec_fields_t f;
        f.rs1       = instr[19:15];
        f.rs2       = instr[24:20];
        f.uses_rs1  = 1'b0;
        f.uses_rs2  = 1'b0;
        f.writes_rd = 1'b0;
        case (instr[6:0])
            OP:            {f.uses_rs1, f.uses_rs2, f.writes_rd} = 3'b111;
            OP_IMM, LOAD:  {f.uses_rs1, f.uses_rs2, f.writes_rd} = 3'b101;
            STORE, BRANCH: {f.uses_rs1, f.uses_rs2, f.writes_rd} = 3'b110;
            JALR:          {f.uses_rs1, f.uses_rs2, f.writes_rd} = 3'b101;
            JAL, LUI, AUIPC: {f.uses_rs1, f.uses_rs2, f.writes_rd} = 3'b001;
            // CSR accesses (funct3 != 0) read rs1 and write rd; ECALL/EBREAK touch nothing.
            SYSTEM: if (instr[14:12] != 3'b000)
                       {f.uses_rs1, f.uses_rs2, f.writes_rd} = 3'b101;
            default: ;
        endcase
        f.rd = f.writes_rd ? instr[11:7] : '0;
        return f;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// operand_fetch_stage_scoreboard: one busy bit per architectural register.
//   clk, rst_n        clock, async active-low reset (all bits clear)
//   set_en, set_idx   mark a register busy (index 0 ignored)
//   clr_en, clr_idx   writeback retiring a register
//   query_a/b         registers to look up
//   busy_a/b          busy, excluding a register retiring this very cycle
module operand_fetch_stage_scoreboard
    import core_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t query_a,
    input  reg_idx_t query_b,
    output logic     busy_a,
    output logic     busy_b
);

    logic [NREGS-1:0] busy_bits;

    // Set is applied after clear, so a register issued and retired in the
    // same cycle stays busy for the newer producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_bits <= '0;
        end else begin
            if (clr_en)
                busy_bits[clr_idx] <= 1'b0;
            if (set_en && set_idx != '0)
                busy_bits[set_idx] <= 1'b1;
        end
    end

    // A same-cycle writeback lands on the negedge, before the posedge read.
    always_comb begin
        busy_a = busy_bits[query_a] && !(clr_en && clr_idx == query_a);
        busy_b = busy_bits[query_b] && !(clr_en && clr_idx == query_b);
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode / operand-fetch between fetch and execute.
//   clk, rst_n, flush             clock, async active-low reset, redirect flush
//   in_valid/in_ready/in_instr/in_pc   fetch handshake
//   rf_read_selA/B, rf_data_outA/B     synchronous register-file read port
//   wb_valid, wb_rd                    writeback retirement
//   out_valid/out_ready/out_instr/out_pc/out_rd/out_rs1_val/out_rs2_val
//                                      execute handshake
// Slot D holds the accepted instruction; slot O holds the one whose operands
// are arriving from the register file and feeds execute.
module operand_fetch_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_read_selA,
    output logic [4:0]      rf_read_selB,
    input  logic [XLEN-1:0] rf_data_outA,
    input  logic [XLEN-1:0] rf_data_outB,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val
);

    logic            d_valid;
    logic [31:0]     d_instr;
    logic [XLEN-1:0] d_pc;
    dec_fields_t     d_dec;

    logic            o_valid;
    logic [31:0]     o_instr;
    logic [XLEN-1:0] o_pc;
    reg_idx_t        o_rs1, o_rs2, o_rd;

    logic sb_busy1, sb_busy2, busy1, busy2, hazard;
    logic move, accept, issue;

    operand_fetch_stage_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (issue),
        .set_idx (o_rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .query_a (d_dec.rs1),
        .query_b (d_dec.rs2),
        .busy_a  (sb_busy1),
        .busy_b  (sb_busy2)
    );

    always_comb begin
        d_dec  = decode_fields(d_instr);
        // O's producer has not issued yet, so it is not in the scoreboard.
        busy1  = sb_busy1 || (o_valid && o_rd == d_dec.rs1);
        busy2  = sb_busy2 || (o_valid && o_rd == d_dec.rs2);
        hazard = (d_dec.uses_rs1 && d_dec.rs1 != '0 && busy1) ||
                 (d_dec.uses_rs2 && d_dec.rs2 != '0 && busy2);
        move     = d_valid && !hazard && (!o_valid || out_ready) && !flush;
        in_ready = (!d_valid || move) && !flush;
        accept   = in_valid && in_ready;
        issue    = o_valid && out_ready && !flush;
        // While O stalls, keep re-reading its sources so the data stays put.
        rf_read_selA = move ? d_dec.rs1 : o_rs1;
        rf_read_selB = move ? d_dec.rs2 : o_rs2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_instr <= '0;
            d_pc    <= '0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (accept) begin
            d_valid <= 1'b1;
            d_instr <= in_instr;
            d_pc    <= in_pc;
        end else if (move) begin
            d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_instr <= '0;
            o_pc    <= '0;
            o_rs1   <= '0;
            o_rs2   <= '0;
            o_rd    <= '0;
        end else if (flush) begin
            o_valid <= 1'b0;
        end else if (move) begin
            o_valid <= 1'b1;
            o_instr <= d_instr;
            o_pc    <= d_pc;
            o_rs1   <= d_dec.rs1;
            o_rs2   <= d_dec.rs2;
            o_rd    <= d_dec.rd;
        end else if (out_ready) begin
            o_valid <= 1'b0;
        end
    end

    always_comb begin
        out_valid   = o_valid;
        out_instr   = o_instr;
        out_pc      = o_pc;
        out_rd      = o_rd;
        out_rs1_val = rf_data_outA;
        out_rs2_val = rf_data_outB;
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios followed by random traffic
// checked against an in-order transaction model with an architectural
// register array and a list of in-flight destinations.
`timescale 1ns/1ps
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, wb_valid, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, rf_data_outA, rf_data_outB, wb_data;
    logic [31:0] out_instr, out_pc, out_rs1_val, out_rs2_val;
    logic [4:0]  rf_read_selA, rf_read_selB, wb_rd, out_rd;

    int n_vec = 0;
    int n_err = 0;

    operand_fetch_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_read_selA(rf_read_selA), .rf_read_selB(rf_read_selB),
        .rf_data_outA(rf_data_outA), .rf_data_outB(rf_data_outB),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val)
    );

    always #5 clk = ~clk;

    // Register file environment: write on negedge, registered read on posedge.
    logic [31:0] rf_mem [32] = '{default: 32'd0};
    always @(negedge clk) if (wb_valid && wb_rd != 5'd0) rf_mem[wb_rd] <= wb_data;
    always @(posedge clk) begin
        rf_data_outA <= rf_mem[rf_read_selA];
        rf_data_outB <= rf_mem[rf_read_selB];
    end

    typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
    typedef struct { logic [4:0] rd; logic [31:0] val; } pend_t;
    exp_t        expq[$];
    pend_t       pend[$];
    logic [31:0] arch [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    // Reference decode: which registers each RV32I opcode class reads/writes.
    function automatic void ref_dec(input logic [31:0] ins, output logic u1, output logic u2,
                                    output logic [4:0] rd);
        logic w;
        case (ins[6:0])
            7'h33:               {u1, u2, w} = 3'b111;
            7'h13, 7'h03, 7'h67: {u1, u2, w} = 3'b101;
            7'h23, 7'h63:        {u1, u2, w} = 3'b110;
            7'h6F, 7'h37, 7'h17: {u1, u2, w} = 3'b001;
            7'h73:               {u1, u2, w} = (ins[14:12] != 3'b000) ? 3'b101 : 3'b000;
            default:             {u1, u2, w} = 3'b000;
        endcase
        rd = w ? ins[11:7] : 5'd0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                  7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B};
        logic [4:0] rs1 = 5'($urandom_range(0, 7));
        logic [4:0] rs2 = 5'($urandom_range(0, 7));
        logic [4:0] rd  = 5'($urandom_range(0, 7));
        return {7'($urandom), rs2, rs1, 3'($urandom), rd, opcs[$urandom_range(0, 10)]};
    endfunction

    function automatic logic pending_on(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (wb_valid && wb_rd == r) return 1'b1;
        foreach (pend[k]) if (pend[k].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [31:0] stream [8];
        logic        offer_valid;
        logic [31:0] offer_instr, offer_pc, pc_ctr, nval;
        logic        u1, u2;
        logic [4:0]  erd, rs1, rs2;
        exp_t        e;
        bit          draining;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;

        // ---- reset values
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_rd", out_rd, 0);
        rst_n = 1'b1;

        // ---- RAW stall on x5, released by a same-cycle writeback
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = mk_i(5'd5, 5'd0, 12'd7); in_pc = 32'h100;
        #2 chk("a_acc0", in_ready, 1);
        tick();
        in_instr = mk_r(5'd6, 5'd5, 5'd5); in_pc = 32'h104;
        #2 chk("a_acc1", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #2 chk("a_o_valid", out_valid, 1);
        chk("a_o_instr", out_instr, mk_i(5'd5, 5'd0, 12'd7));
        chk("a_o_rd", out_rd, 5);
        chk("a_stall_o", in_ready, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #2 chk("a_stall_valid", out_valid, 0);
            chk("a_stall_ready", in_ready, 0);
            tick();
        end
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        #2 chk("a_bypass_ready", in_ready, 1);
        tick();
        wb_valid = 1'b0;
        #2 chk("a_issue_valid", out_valid, 1);
        chk("a_issue_pc", out_pc, 32'h104);
        chk("a_issue_rd", out_rd, 6);
        chk("a_rs1_new", out_rs1_val, 32'h1234);
        chk("a_rs2_new", out_rs2_val, 32'h1234);

        // ---- asynchronous reset while D is stalled on x6
        in_valid = 1'b1; in_instr = mk_r(5'd7, 5'd6, 5'd6); in_pc = 32'h108;
        tick();
        in_valid = 1'b0;
        #1 chk("r_pre_stall", in_ready, 0);
        rst_n = 1'b0;
        #1 chk("r_async_ready", in_ready, 1);
        chk("r_async_valid", out_valid, 0);
        chk("r_async_rd", out_rd, 0);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_instr = mk_r(5'd9, 5'd6, 5'd5); in_pc = 32'h110;
        tick();
        in_valid = 1'b0;
        tick();
        #2 chk("r_sb_clear_valid", out_valid, 1);
        chk("r_sb_clear_pc", out_pc, 32'h110);
        chk("r_rs2", out_rs2_val, 32'h1234);

        // ---- O held with x1=0xDEAD while execute stalls
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD;
        in_valid = 1'b1; in_instr = mk_r(5'd2, 5'd1, 5'd0); in_pc = 32'h114;
        tick();
        wb_valid = 1'b0; out_ready = 1'b0;
        in_instr = mk_r(5'd3, 5'd5, 5'd5); in_pc = 32'h118;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2 chk("h_valid", out_valid, 1);
            chk("h_rs1", out_rs1_val, 32'hDEAD);
            chk("h_pc", out_pc, 32'h114);
            chk("h_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        #2 chk("h_next_pc", out_pc, 32'h118);
        chk("h_next_rs1", out_rs1_val, 32'h1234);

        // ---- flush with D and O both valid
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk_i(5'd4, 5'd0, 12'd3); in_pc = 32'h11C;
        tick();
        in_valid = 1'b0;
        #2 chk("f_o_full", out_valid, 1);
        chk("f_d_full", in_ready, 0);
        flush = 1'b1;
        #1 chk("f_block", in_ready, 0);
        tick();
        flush = 1'b0;
        #2 chk("f_o_drop", out_valid, 0);
        chk("f_d_drop", in_ready, 1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = mk_r(5'd10, 5'd4, 5'd4); in_pc = 32'h120;
        tick();
        in_valid = 1'b0;
        tick();
        #2 chk("f_next_valid", out_valid, 1);
        chk("f_next_pc", out_pc, 32'h120);
        in_valid = 1'b1; in_instr = mk_r(5'd11, 5'd2, 5'd2); in_pc = 32'h124;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2 chk("f_sb_kept", out_valid, 0);
            tick();
        end
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h77;
        tick();
        wb_valid = 1'b0;
        #2 chk("f_rel_pc", out_pc, 32'h124);
        chk("f_rel_rs1", out_rs1_val, 32'h77);

        // ---- back-to-back independent stream, x0 never a hazard
        stream[0] = mk_i(5'd12, 5'd0, 12'd1);  stream[1] = mk_i(5'd0, 5'd0, 12'd1);
        stream[2] = mk_r(5'd13, 5'd0, 5'd0);   stream[3] = mk_i(5'd14, 5'd0, 12'd2);
        stream[4] = mk_r(5'd15, 5'd0, 5'd0);   stream[5] = mk_i(5'd0, 5'd0, 12'd5);
        stream[6] = mk_i(5'd16, 5'd0, 12'd3);  stream[7] = mk_r(5'd17, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            in_instr = stream[i % 8];
            in_pc = 32'h200 + 32'(4 * i);
            #2;
            if (i < 8) chk("b_in_ready", in_ready, 1);
            if (i >= 2) begin
                chk("b_out_valid", out_valid, 1);
                chk("b_out_pc", out_pc, 32'h200 + 32'(4 * (i - 2)));
            end
            tick();
        end
        in_valid = 1'b0;

        // ---- random traffic against the transaction model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        foreach (arch[k]) arch[k] = rf_mem[k];
        offer_valid = 1'b0; offer_instr = '0; offer_pc = '0; pc_ctr = 32'h1000;
        for (int cyc = 0; cyc < 3400; cyc++) begin
            draining = (cyc >= 3000);
            if (draining && !offer_valid && expq.size() == 0 && pend.size() == 0) break;
            flush = !draining && ($urandom_range(0, 39) == 0);
            out_ready = !flush && (draining || $urandom_range(0, 9) < 7);
            if (!offer_valid && !draining && $urandom_range(0, 3) != 0) begin
                offer_valid = 1'b1; offer_instr = rand_instr(); offer_pc = pc_ctr;
                pc_ctr += 32'd4;
            end
            in_valid = offer_valid; in_instr = offer_instr; in_pc = offer_pc;
            wb_valid = 1'b0;
            if (pend.size() != 0 && (draining || $urandom_range(0, 9) < 4)) begin
                int j;
                j = $urandom_range(0, pend.size() - 1);
                wb_valid = 1'b1; wb_rd = pend[j].rd; wb_data = pend[j].val;
                pend.delete(j);
            end
            #3;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("x_spurious_issue", 1, 0);
                end else begin
                    e = expq.pop_front();
                    ref_dec(e.instr, u1, u2, erd);
                    rs1 = e.instr[19:15]; rs2 = e.instr[24:20];
                    chk("x_instr", out_instr, e.instr);
                    chk("x_pc", out_pc, e.pc);
                    chk("x_rd", out_rd, erd);
                    if (u1) begin
                        chk("x_raw_rs1", pending_on(rs1), 0);
                        chk("x_rs1_val", out_rs1_val, arch[rs1]);
                    end
                    if (u2) begin
                        chk("x_raw_rs2", pending_on(rs2), 0);
                        chk("x_rs2_val", out_rs2_val, arch[rs2]);
                    end
                    if (erd != 5'd0) begin
                        for (int k = pend.size() - 1; k >= 0; k--)
                            if (pend[k].rd == erd) pend.delete(k);
                        nval = $urandom;
                        pend.push_back('{rd: erd, val: nval});
                    end
                end
            end
            if (wb_valid && wb_rd != 5'd0) arch[wb_rd] = wb_data;
            if (in_valid && in_ready && !flush) begin
                expq.push_back('{instr: offer_instr, pc: offer_pc});
                offer_valid = 1'b0;
            end
            if (flush) expq.delete();
            tick();
        end
        in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
        chk("x_drain_expq", 32'(expq.size()), 0);
        chk("x_drain_pend", 32'(pend.size()), 0);
        chk("x_drain_offer", offer_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
